// File: rtl/uart_rx_param.sv
// uart_rx_param -- oversampling UART receiver with a first-word-fall-through
// receive FIFO and sticky error flags.
//
// Build option: define UART_RX_PARITY_EN to expect one parity bit between the
// data bits and the stop bit(s). Without it, frames carry no parity bit and
// Parity_error is held at 0.
//
// Ports
//   Clock_50      in   single clock, rising edge
//   Resetn        in   asynchronous active-low reset
//   Enable        in   receiver enable; low aborts any frame in progress
//   UART_RX_I     in   asynchronous serial line, idle high
//   Rx_data       out  FIFO head entry (0 while empty)
//   Rx_valid      out  FIFO non-empty
//   Rx_ready      in   consumer accepts Rx_data (pop when Rx_valid && Rx_ready)
//   Full          out  FIFO full
//   Frame_error   out  sticky: low stop-bit sample seen
//   Parity_error  out  sticky: parity mismatch seen
//   Overrun       out  sticky: good byte dropped because the FIFO was full
//   Clear_errors  in   clears the sticky flags (a same-cycle set wins)
`timescale 1ns/1ps
module uart_rx_param #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 Clock_50,
  input  logic                 Resetn,
  input  logic                 Enable,
  input  logic                 UART_RX_I,
  output logic [DATA_BITS-1:0] Rx_data,
  output logic                 Rx_valid,
  input  logic                 Rx_ready,
  output logic                 Full,
  output logic                 Frame_error,
  output logic                 Parity_error,
  output logic                 Overrun,
  input  logic                 Clear_errors
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;
  localparam int IDX_W = PTR_W - 1;
  localparam int BC_W  = 3;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BC_W-1:0]  DATA_LAST = BC_W'(DATA_BITS - 1);
  localparam logic [BC_W-1:0]  STOP_LAST = BC_W'(STOP_BITS - 1);

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  state_t                 state, state_nx;
  logic [CNT_W-1:0]       cnt, cnt_nx;
  logic [BC_W-1:0]        bit_cnt, bit_nx;
  logic [DATA_BITS-1:0]   shreg, shreg_nx;
  logic                   push, set_fe, set_pe;
  logic                   rx_sync_p0, rx_sync_p1, vld_p0, vld_p1, rx_hi;
  logic                   fall, par_exp;
  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic                   empty, pop, wr_en, ovr_set;
  logic                   fe_q, pe_q, ov_q;

  // ---- stage p0/p1: line synchroniser ----
  // vld_pN marks when rx_sync_pN holds a real line sample rather than its
  // reset value, so a line held low through reset never looks like a start.
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      rx_hi      <= 1'b0;
    end else begin
      rx_sync_p0 <= UART_RX_I;
      rx_sync_p1 <= rx_sync_p0;
      vld_p0     <= 1'b1;
      vld_p1     <= vld_p0;
      rx_hi      <= vld_p1 & rx_sync_p1;
    end
  end

  assign fall    = rx_hi & ~rx_sync_p1;
  assign par_exp = (^shreg) ^ (PARITY_ODD != 0);

  // ---- frame FSM ----
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_cnt <= bit_nx;
    end
  end

  always_ff @(posedge Clock_50) begin
    shreg <= shreg_nx;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 1'b1;
    bit_nx   = bit_cnt;
    shreg_nx = shreg;
    push     = 1'b0;
    set_fe   = 1'b0;
    set_pe   = 1'b0;
    if (!Enable) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      bit_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_nx = '0;
          bit_nx = '0;
          if (fall) state_nx = START;
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt_nx   = '0;
            state_nx = rx_sync_p1 ? IDLE : DATA;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt_nx   = '0;
            shreg_nx = {rx_sync_p1, shreg[DATA_BITS-1:1]};
            if (bit_cnt == DATA_LAST) begin
              bit_nx   = '0;
              state_nx = PAR_EN ? PARITY : STOP;
            end else begin
              bit_nx = bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (cnt == BIT_LAST) begin
            cnt_nx = '0;
            if (rx_sync_p1 != par_exp) begin
              set_pe   = PAR_EN;
              state_nx = IDLE;
            end else begin
              state_nx = STOP;
            end
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt_nx = '0;
            if (!rx_sync_p1) begin
              set_fe   = 1'b1;
              bit_nx   = '0;
              state_nx = WAIT_HIGH;
            end else if (bit_cnt == STOP_LAST) begin
              bit_nx   = '0;
              push     = 1'b1;
              state_nx = IDLE;
            end else begin
              bit_nx = bit_cnt + 1'b1;
            end
          end
        end
        WAIT_HIGH: begin
          cnt_nx = '0;
          if (rx_sync_p1) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // ---- receive FIFO ----
  // Pointers carry one extra wrap bit: equal pointers mean empty, equal
  // indices with differing wrap bits mean full.
  assign empty   = (wr_ptr == rd_ptr);
  assign Full    = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                   (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign Rx_valid = ~empty;
  assign pop     = Rx_valid & Rx_ready;
  assign wr_en   = push & (~Full | pop);
  assign ovr_set = push & Full & ~pop;
  assign Rx_data = empty ? '0 : mem[rd_ptr[IDX_W-1:0]];

  always_ff @(posedge Clock_50) begin
    if (wr_en) mem[wr_ptr[IDX_W-1:0]] <= shreg;
  end

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // ---- sticky flags: a set in the same cycle as Clear_errors wins ----
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      fe_q <= 1'b0;
      pe_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      fe_q <= set_fe  | (fe_q & ~Clear_errors);
      pe_q <= set_pe  | (pe_q & ~Clear_errors);
      ov_q <= ovr_set | (ov_q & ~Clear_errors);
    end
  end

  assign Frame_error  = fe_q;
  assign Parity_error = pe_q & PAR_EN;
  assign Overrun      = ov_q;

endmodule
